// File: rtl/div_pkg.sv
// Shared types and constants for the divider arbiter slice.
package div_pkg;

    localparam int DIV_WIDTH = 5;
    localparam int NREQ      = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic ERR_NONE  = 1'b0;
    localparam logic ERR_DIV0  = 1'b1;
    localparam logic ERR_ABORT = 1'b1;

    function automatic logic [NREQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic [0:0] last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last[0] ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one repeated-subtraction divider between two requesters: arbitrates,
// latches operands, sequences load/run, detects completion and returns results.
module div_arbiter
    import div_pkg::*;
#(
    parameter int WIDTH     = DIV_WIDTH,
    parameter int RUN_LIMIT = 2**WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    output logic [1:0]           gnt,
    output logic [1:0]           rsp_valid,
    output logic [WIDTH-1:0]     rsp_q,
    output logic [WIDTH-1:0]     rsp_r,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 div_load,
    output logic [WIDTH-1:0]     div_a,
    output logic [WIDTH-1:0]     div_b,
    input  logic [WIDTH-1:0]     div_q,
    input  logic [WIDTH-1:0]     div_r
);

    localparam int CW = $clog2(RUN_LIMIT);

    state_t            state;
    logic              id;
    logic [0:0]        last;
    logic [CW-1:0]     cnt;
    logic [1:0]        arb_gnt;
    logic              win;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;

    rr_arb2 u_arb (
        .req  (req),
        .last (last),
        .gnt  (arb_gnt)
    );

    assign win   = arb_gnt[1];
    assign sel_a = win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign sel_b = win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

    // Grant is visible in the IDLE cycle itself so the operands are latched on that edge.
    assign gnt  = (state == IDLE && !rst) ? arb_gnt : 2'b00;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            id        <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            div_load  <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            rsp_valid <= 2'b00;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_err   <= ERR_NONE;
        end else begin
            div_load  <= 1'b0;
            rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (|arb_gnt) begin
                        id    <= win;
                        last  <= win;
                        div_a <= sel_a;
                        div_b <= sel_b;
                        if (sel_b == '0) begin
                            rsp_q     <= '1;
                            rsp_r     <= sel_a;
                            rsp_err   <= ERR_DIV0;
                            rsp_valid <= req_onehot(win);
                            state     <= DONE;
                        end else begin
                            div_load <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                // The divider subtracts once per cycle; stop as soon as the remainder drops below b.
                RUN: begin
                    if (div_r < div_b) begin
                        rsp_q     <= div_q;
                        rsp_r     <= div_r;
                        rsp_err   <= ERR_NONE;
                        rsp_valid <= req_onehot(id);
                        state     <= DONE;
                    end else if (cnt == CW'(RUN_LIMIT - 1)) begin
                        rsp_q     <= div_q;
                        rsp_r     <= div_r;
                        rsp_err   <= ERR_ABORT;
                        rsp_valid <= req_onehot(id);
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter with a behavioural repeated-subtraction divider attached.
module tb_div_arbiter;

    localparam int W         = 5;
    localparam int RUN_LIMIT = 2**W + 1;

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [W-1:0]     ra [2];
    logic [W-1:0]     rb [2];
    logic [2*W-1:0]   req_a;
    logic [2*W-1:0]   req_b;
    logic [1:0]       gnt;
    logic [1:0]       rsp_valid;
    logic [W-1:0]     rsp_q;
    logic [W-1:0]     rsp_r;
    logic             rsp_err;
    logic             busy;
    logic             div_load;
    logic [W-1:0]     div_a;
    logic [W-1:0]     div_b;
    logic [W-1:0]     dv_q = '0;
    logic [W-1:0]     dv_r = '0;
    logic             freeze;

    int checks   = 0;
    int failures = 0;
    int load_count = 0;
    int overlap    = 0;

    assign req_a = {ra[1], ra[0]};
    assign req_b = {rb[1], rb[0]};

    div_arbiter #(.WIDTH(W), .RUN_LIMIT(RUN_LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .div_load  (div_load),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_q     (dv_q),
        .div_r     (dv_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stand-in; freeze makes it stall so the run-limit abort can be reached.
    always @(posedge clk) begin
        if (div_load) begin
            dv_r <= div_a;
            dv_q <= '0;
        end else if (!freeze && div_b != '0 && dv_r >= div_b) begin
            dv_r <= dv_r - div_b;
            dv_q <= dv_q + 5'd1;
        end
    end

    always @(posedge clk) if (div_load === 1'b1) load_count <= load_count + 1;
    always @(negedge clk) if ((|gnt) && (|rsp_valid)) overlap <= overlap + 1;

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return '1;
        return a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return a;
        return a % b;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return 1;
        return 3 + int'(a / b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic wait_rsp(output int n);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            mid();
            if (rsp_valid !== 2'b00) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b00;
        tick();
        req = 2'b11;
        ra[0] = 5'd9; rb[0] = 5'd3; ra[1] = 5'd7; rb[1] = 5'd2;
        tick();
        mid();
        checks++;
        if ({gnt, rsp_valid, rsp_q, rsp_r, rsp_err, busy, div_load, div_a, div_b} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs: got gnt=%b vld=%b q=%0d r=%0d err=%b busy=%b load=%b a=%0d b=%0d expected all zero",
                     gnt, rsp_valid, rsp_q, rsp_r, rsp_err, busy, div_load, div_a, div_b);
        end
        tick();
        rst = 1'b0;
        req = 2'b00;
    endtask

    task automatic test_tie();
        int n;
        tick();
        req = 2'b11;
        ra[0] = 5'd9; rb[0] = 5'd3; ra[1] = 5'd7; rb[1] = 5'd2;
        mid();
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL tie_first_gnt: got %b expected 01", gnt); end
        tick();
        req = 2'b10;
        wait_rsp(n);
        checks++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_err} !== {2'b01, 5'd3, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL tie_rsp0: got vld=%b q=%0d r=%0d err=%b expected 01 3 0 0", rsp_valid, rsp_q, rsp_r, rsp_err);
        end
        tick();
        mid();
        checks++;
        if (gnt !== 2'b10) begin failures++; $display("FAIL tie_second_gnt: got %b expected 10", gnt); end
        tick();
        req = 2'b00;
        wait_rsp(n);
        checks++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_err} !== {2'b10, 5'd3, 5'd1, 1'b0}) begin
            failures++;
            $display("FAIL tie_rsp1: got vld=%b q=%0d r=%0d err=%b expected 10 3 1 0", rsp_valid, rsp_q, rsp_r, rsp_err);
        end
    endtask

    task automatic test_single();
        int n;
        tick();
        req = 2'b01;
        ra[0] = 5'd13; rb[0] = 5'd4;
        mid();
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt: got %b expected 01", gnt); end
        tick();
        req = 2'b00;
        mid();
        checks++;
        if ({div_load, busy, div_a, div_b} !== {1'b1, 1'b1, 5'd13, 5'd4}) begin
            failures++;
            $display("FAIL single_load: got load=%b busy=%b a=%0d b=%0d expected 1 1 13 4", div_load, busy, div_a, div_b);
        end
        wait_rsp(n);
        checks++;
        if (n + 1 != 6) begin failures++; $display("FAIL single_latency: got %0d expected 6", n + 1); end
        checks++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_err} !== {2'b01, 5'd3, 5'd1, 1'b0}) begin
            failures++;
            $display("FAIL single_rsp: got vld=%b q=%0d r=%0d err=%b expected 01 3 1 0", rsp_valid, rsp_q, rsp_r, rsp_err);
        end
        tick();
        mid();
        checks++;
        if ({rsp_valid, rsp_q, rsp_r, busy} !== {2'b00, 5'd3, 5'd1, 1'b0}) begin
            failures++;
            $display("FAIL single_hold: got vld=%b q=%0d r=%0d busy=%b expected 00 3 1 0", rsp_valid, rsp_q, rsp_r, busy);
        end
    endtask

    task automatic test_div0();
        int lc;
        tick();
        req = 2'b10;
        ra[1] = 5'd6; rb[1] = 5'd0;
        lc = load_count;
        mid();
        checks++;
        if (gnt !== 2'b10) begin failures++; $display("FAIL div0_gnt: got %b expected 10", gnt); end
        tick();
        req = 2'b00;
        mid();
        checks++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_err, div_load} !== {2'b10, 5'd31, 5'd6, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL div0_rsp: got vld=%b q=%0d r=%0d err=%b load=%b expected 10 31 6 1 0",
                     rsp_valid, rsp_q, rsp_r, rsp_err, div_load);
        end
        checks++;
        if (load_count != lc) begin failures++; $display("FAIL div0_no_load: got %0d loads expected %0d", load_count, lc); end
    endtask

    task automatic test_round_robin();
        int n;
        tick();
        req = 2'b01;
        ra[0] = 5'd10; rb[0] = 5'd5;
        mid();
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL rr_gnt0: got %b expected 01", gnt); end
        tick();
        req = 2'b11;
        ra[1] = 5'd4; rb[1] = 5'd2;
        wait_rsp(n);
        checks++;
        if ({rsp_valid, gnt, rsp_q, rsp_r} !== {2'b01, 2'b00, 5'd2, 5'd0} || n + 1 != 5) begin
            failures++;
            $display("FAIL rr_rsp0: got vld=%b gnt=%b q=%0d r=%0d lat=%0d expected 01 00 2 0 5",
                     rsp_valid, gnt, rsp_q, rsp_r, n + 1);
        end
        tick();
        mid();
        checks++;
        if (gnt !== 2'b10) begin failures++; $display("FAIL rr_gnt1: got %b expected 10", gnt); end
        tick();
        req = 2'b01;
        wait_rsp(n);
        checks++;
        if ({rsp_valid, rsp_q, rsp_r} !== {2'b10, 5'd2, 5'd0}) begin
            failures++;
            $display("FAIL rr_rsp1: got vld=%b q=%0d r=%0d expected 10 2 0", rsp_valid, rsp_q, rsp_r);
        end
        tick();
        mid();
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL rr_gnt2: got %b expected 01", gnt); end
        tick();
        req = 2'b00;
        wait_rsp(n);
    endtask

    task automatic test_boundaries();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        int n;
        ta[0] = 5'd2;  tb[0] = 5'd5;
        ta[1] = 5'd31; tb[1] = 5'd1;
        ta[2] = 5'd7;  tb[2] = 5'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            req = 2'b01;
            ra[0] = ta[i]; rb[0] = tb[i];
            mid();
            tick();
            req = 2'b00;
            wait_rsp(n);
            checks++;
            if (n + 1 != ref_lat(ta[i], tb[i])) begin
                failures++;
                $display("FAIL bound_latency %0d/%0d: got %0d expected %0d", ta[i], tb[i], n + 1, ref_lat(ta[i], tb[i]));
            end
            checks++;
            if ({rsp_q, rsp_r, rsp_err} !== {ref_q(ta[i], tb[i]), ref_r(ta[i], tb[i]), 1'b0}) begin
                failures++;
                $display("FAIL bound_rsp %0d/%0d: got q=%0d r=%0d err=%b expected %0d %0d 0",
                         ta[i], tb[i], rsp_q, rsp_r, rsp_err, ref_q(ta[i], tb[i]), ref_r(ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_abort();
        int n;
        freeze = 1'b1;
        tick();
        req = 2'b01;
        ra[0] = 5'd20; rb[0] = 5'd3;
        mid();
        tick();
        req = 2'b00;
        wait_rsp(n);
        checks++;
        if (n + 1 != 3 + RUN_LIMIT - 1) begin
            failures++;
            $display("FAIL abort_latency: got %0d expected %0d", n + 1, 3 + RUN_LIMIT - 1);
        end
        checks++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_err} !== {2'b01, 5'd0, 5'd20, 1'b1}) begin
            failures++;
            $display("FAIL abort_rsp: got vld=%b q=%0d r=%0d err=%b expected 01 0 20 1", rsp_valid, rsp_q, rsp_r, rsp_err);
        end
        freeze = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int n;
        tick();
        req = 2'b01;
        ra[0] = 5'd30; rb[0] = 5'd2;
        mid();
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        mid();
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_running: got vld=%b busy=%b expected 00 1", rsp_valid, busy);
        end
        tick();
        mid();
        checks++;
        if ({gnt, rsp_valid, rsp_q, rsp_r, rsp_err, busy, div_load, div_a, div_b} !== 27'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: got gnt=%b vld=%b q=%0d r=%0d err=%b busy=%b load=%b a=%0d b=%0d expected all zero",
                     gnt, rsp_valid, rsp_q, rsp_r, rsp_err, busy, div_load, div_a, div_b);
        end
        tick();
        rst = 1'b0;
        mid();
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL rstmid_regrant: got %b expected 01", gnt); end
        tick();
        req = 2'b00;
        wait_rsp(n);
        checks++;
        if ({rsp_valid, rsp_q, rsp_r, rsp_err} !== {2'b01, 5'd15, 5'd0, 1'b0} || n + 1 != 18) begin
            failures++;
            $display("FAIL rstmid_rsp: got vld=%b q=%0d r=%0d err=%b lat=%0d expected 01 15 0 0 18",
                     rsp_valid, rsp_q, rsp_r, rsp_err, n + 1);
        end
    endtask

    // Scheduling model: the shared unit is free again one cycle after each response.
    task automatic test_random();
        int cyc, idle_at, rsp_at, grant_at, issued;
        logic pend [2];
        logic m_last, rid, ee, w, exp_busy;
        logic [1:0] eg, er;
        logic [W-1:0] eq, erm;
        rst = 1'b1;
        req = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0; idle_at = 0; rsp_at = -1; grant_at = -100; issued = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        m_last = 1'b1; rid = 1'b0; eq = '0; erm = '0; ee = 1'b0;
        for (int it = 0; it < 4000; it++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && issued < 40 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    ra[i] = 5'($urandom);
                    rb[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    issued++;
                end else if (pend[i] && cyc < idle_at && $urandom_range(0, 29) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            req = {pend[1], pend[0]};
            mid();
            eg = 2'b00;
            if (cyc >= idle_at && req != 2'b00) begin
                w = (req == 2'b11) ? ~m_last : req[1];
                eg = w ? 2'b10 : 2'b01;
                eq = ref_q(ra[w], rb[w]);
                erm = ref_r(ra[w], rb[w]);
                ee = (rb[w] == '0);
                rsp_at = cyc + ref_lat(ra[w], rb[w]);
                idle_at = rsp_at + 1;
                grant_at = cyc;
                rid = w;
                m_last = w;
                pend[w] = 1'b0;
            end
            checks++;
            if (gnt !== eg) begin failures++; $display("FAIL rnd_gnt cyc %0d: got %b expected %b", cyc, gnt, eg); end
            er = (cyc == rsp_at) ? (rid ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (rsp_valid !== er) begin failures++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", cyc, rsp_valid, er); end
            if (cyc == rsp_at) begin
                checks++;
                if ({rsp_q, rsp_r, rsp_err} !== {eq, erm, ee}) begin
                    failures++;
                    $display("FAIL rnd_rsp cyc %0d: got q=%0d r=%0d err=%b expected %0d %0d %b", cyc, rsp_q, rsp_r, rsp_err, eq, erm, ee);
                end
            end
            exp_busy = (cyc > grant_at) && (cyc < idle_at);
            checks++;
            if (busy !== exp_busy) begin failures++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", cyc, busy, exp_busy); end
            cyc++;
            if (issued >= 40 && !pend[0] && !pend[1] && cyc >= idle_at) break;
        end
        req = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00;
        freeze = 1'b0;
        ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
        test_reset();
        test_tie();
        test_single();
        test_div0();
        test_round_robin();
        test_boundaries();
        test_abort();
        test_reset_mid_run();
        test_random();
        checks++;
        if (overlap != 0) begin failures++; $display("FAIL gnt_rsp_overlap: got %0d cycles expected 0", overlap); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
